// File: rtl/arp_lookup_arbiter.sv
// Round-robin arbiter sharing one ARP CAM lookup port between the LPM and CCCP
// next-hop paths; one lookup outstanding at a time, with ack timeout.
module arp_lookup_arbiter #(
    parameter int CMP_WIDTH    = 32,
    parameter int DATA_WIDTH   = 48,
    parameter int Q_DEPTH_BITS = 1,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  lpm_req,
    input  logic [CMP_WIDTH-1:0]  lpm_ip,
    output logic                  lpm_busy,
    output logic                  lpm_ack,
    output logic                  lpm_hit,
    output logic [DATA_WIDTH-1:0] lpm_mac,

    input  logic                  cccp_req,
    input  logic [CMP_WIDTH-1:0]  cccp_ip,
    output logic                  cccp_busy,
    output logic                  cccp_ack,
    output logic                  cccp_hit,
    output logic [DATA_WIDTH-1:0] cccp_mac,

    output logic                  lut_lookup_req,
    output logic [CMP_WIDTH-1:0]  lut_lookup_cmp_data,
    input  logic                  lut_lookup_ack,
    input  logic                  lut_lookup_hit,
    input  logic [DATA_WIDTH-1:0] lut_lookup_data,

    output logic [15:0]           timeout_cnt,
    output logic [15:0]           drop_cnt
);

    localparam int DEPTH = 1 << Q_DEPTH_BITS;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic LPM  = 1'b0;
    localparam logic CCCP = 1'b1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state_q, state_d;

    logic [1:0]              req_v, push_v, pop_v, drop_v, nonempty, q_full;
    logic [CMP_WIDTH-1:0]    ip_v   [2];
    logic [CMP_WIDTH-1:0]    q_mem  [2][DEPTH];
    logic [Q_DEPTH_BITS-1:0] q_wr   [2];
    logic [Q_DEPTH_BITS-1:0] q_rd   [2];
    logic [Q_DEPTH_BITS:0]   q_cnt  [2];
    logic [Q_DEPTH_BITS:0]   q_cnt_d[2];

    logic                    owner_q, rr_q, grant, grant_sel;
    logic                    complete, comp_hit, tmo;
    logic [DATA_WIDTH-1:0]   comp_mac;
    logic [TW-1:0]           timer_q;
    logic [16:0]             drop_sum;

    assign req_v     = {cccp_req, lpm_req};
    assign ip_v[0]   = lpm_ip;
    assign ip_v[1]   = cccp_ip;
    assign lpm_busy  = q_full[0];
    assign cccp_busy = q_full[1];

    assign lut_lookup_req = (state_q == ISSUE);
    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_v[0]) + 17'(drop_v[1]);

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            push_v[r]   = req_v[r] && !q_full[r];
            drop_v[r]   = req_v[r] && q_full[r];
            pop_v[r]    = complete && (owner_q == 1'(r));
            nonempty[r] = (q_cnt[r] != '0);
            q_cnt_d[r]  = q_cnt[r] + (Q_DEPTH_BITS+1)'(push_v[r]) - (Q_DEPTH_BITS+1)'(pop_v[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_full <= '0;
            for (int r = 0; r < 2; r++) begin
                q_wr[r]  <= '0;
                q_rd[r]  <= '0;
                q_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                if (push_v[r]) q_wr[r] <= q_wr[r] + 1'b1;
                if (pop_v[r])  q_rd[r] <= q_rd[r] + 1'b1;
                q_cnt[r]  <= q_cnt_d[r];
                q_full[r] <= (q_cnt_d[r] == (Q_DEPTH_BITS+1)'(DEPTH));
            end
        end
    end

    // NOTE: queue storage is deliberately not reset; the counts and pointers
    // decide which entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (push_v[r]) q_mem[r][q_wr[r]] <= ip_v[r];
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        grant_sel = LPM;
        complete  = 1'b0;
        comp_hit  = 1'b0;
        comp_mac  = '0;
        tmo       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|nonempty) begin
                    grant     = 1'b1;
                    grant_sel = (&nonempty) ? rr_q : nonempty[1];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (lut_lookup_ack) begin
                    complete = 1'b1;
                    comp_hit = lut_lookup_hit;
                    comp_mac = lut_lookup_data;
                    state_d  = IDLE;
                end else begin
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                // TIMEOUT full WAIT cycles may pass without an ack; the miss is taken on the next one.
                if (lut_lookup_ack) begin
                    complete = 1'b1;
                    comp_hit = lut_lookup_hit;
                    comp_mac = lut_lookup_data;
                    state_d  = IDLE;
                end else if (timer_q == TW'(TIMEOUT)) begin
                    complete = 1'b1;
                    tmo      = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q             <= LPM;
            rr_q                <= LPM;
            timer_q             <= '0;
            lut_lookup_cmp_data <= '0;
            lpm_ack             <= 1'b0;
            lpm_hit             <= 1'b0;
            lpm_mac             <= '0;
            cccp_ack            <= 1'b0;
            cccp_hit            <= 1'b0;
            cccp_mac            <= '0;
            timeout_cnt         <= '0;
            drop_cnt            <= '0;
        end else begin
            if (grant) begin
                owner_q             <= grant_sel;
                lut_lookup_cmp_data <= q_mem[grant_sel][q_rd[grant_sel]];
            end
            if (state_q == ISSUE)     timer_q <= '0;
            else if (state_q == WAIT) timer_q <= timer_q + TW'(1);

            lpm_ack  <= complete && (owner_q == LPM);
            cccp_ack <= complete && (owner_q == CCCP);
            if (complete && owner_q == LPM) begin
                lpm_hit <= comp_hit;
                lpm_mac <= comp_mac;
            end
            if (complete && owner_q == CCCP) begin
                cccp_hit <= comp_hit;
                cccp_mac <= comp_mac;
            end
            if (complete) rr_q <= ~owner_q;

            if (tmo && timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_arp_lookup_arbiter.sv
// Bench for arp_lookup_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based transaction model with a bench-side ARP CAM.
module tb_arp_lookup_arbiter;

    localparam int CW    = 32;
    localparam int DW    = 48;
    localparam int QB    = 1;
    localparam int DEPTH = 2;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          lpm_req = 1'b0, cccp_req = 1'b0;
    logic [CW-1:0] lpm_ip = '0, cccp_ip = '0;
    logic          lpm_busy, lpm_ack, lpm_hit, cccp_busy, cccp_ack, cccp_hit;
    logic [DW-1:0] lpm_mac, cccp_mac;
    logic          lut_lookup_req;
    logic [CW-1:0] lut_lookup_cmp_data;
    logic          lut_lookup_ack = 1'b0, lut_lookup_hit = 1'b0;
    logic [DW-1:0] lut_lookup_data = '0;
    logic [15:0]   timeout_cnt, drop_cnt;

    always #5 clk = ~clk;

    arp_lookup_arbiter #(.CMP_WIDTH(CW), .DATA_WIDTH(DW), .Q_DEPTH_BITS(QB), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .lpm_req(lpm_req), .lpm_ip(lpm_ip), .lpm_busy(lpm_busy), .lpm_ack(lpm_ack),
        .lpm_hit(lpm_hit), .lpm_mac(lpm_mac),
        .cccp_req(cccp_req), .cccp_ip(cccp_ip), .cccp_busy(cccp_busy), .cccp_ack(cccp_ack),
        .cccp_hit(cccp_hit), .cccp_mac(cccp_mac),
        .lut_lookup_req(lut_lookup_req), .lut_lookup_cmp_data(lut_lookup_cmp_data),
        .lut_lookup_ack(lut_lookup_ack), .lut_lookup_hit(lut_lookup_hit),
        .lut_lookup_data(lut_lookup_data),
        .timeout_cnt(timeout_cnt), .drop_cnt(drop_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: per-requester key queues with the cycle each key was accepted.
    logic [31:0] mq_key [2][$];
    int          mq_cyc [2][$];
    int          occ [2];
    int          m_rr = 0, m_tmo = 0, m_drop = 0;
    bit          outst = 1'b0, cur_tmo = 1'b0;
    int          owner = 0, issue_cyc = -1, done_cyc = -1;
    logic [31:0] cur_key = '0;
    int          exp_ack_cyc = -1, exp_port = 0;
    bit          exp_hit = 1'b0;
    logic [47:0] exp_mac = '0;
    int          lat_mode = 1;
    int          stale_at = -1;

    // Observations of the DUT used by scenario-level checks.
    int n_lpm_ack = 0, n_cccp_ack = 0, last_req_cyc = 0, last_cccp_ack_cyc = 0;
    bit obs_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bench-side ARP CAM contents.
    function automatic logic [48:0] cam(input logic [31:0] key);
        if (key == 32'h0A00_0001) return {1'b1, 48'h0011_2233_4455};
        return {key[2] ^ key[5], 16'h5A00 ^ key[31:16], key};
    endfunction

    // Ack latency measured from the lut_lookup_req cycle; -1 means never ack.
    function automatic int pick_latency();
        int x;
        if (lat_mode != -2) return lat_mode;
        x = $urandom_range(0, 99);
        if (x < 8)  return -1;
        if (x < 11) return TMO + 1;
        if (x < 14) return TMO;
        return $urandom_range(0, 5);
    endfunction

    task automatic step(input bit lreq, input logic [31:0] lip,
                        input bit creq, input logic [31:0] cip, input bit rst);
        bit          e_ack0, e_ack1, e_req, v0, v1, acc0, acc1;
        int          lat;
        logic [48:0] rsp;
        @(negedge clk);

        e_ack0 = (exp_ack_cyc == cyc) && (exp_port == 0);
        e_ack1 = (exp_ack_cyc == cyc) && (exp_port == 1);
        check("lpm_ack", lpm_ack, e_ack0);
        if (e_ack0) begin
            check("lpm_hit", lpm_hit, exp_hit);
            check("lpm_mac", lpm_mac, exp_mac);
        end
        check("cccp_ack", cccp_ack, e_ack1);
        if (e_ack1) begin
            check("cccp_hit", cccp_hit, exp_hit);
            check("cccp_mac", cccp_mac, exp_mac);
        end
        e_req = outst && (issue_cyc == cyc);
        check("lut_req", lut_lookup_req, e_req);
        if (e_req) check("cmp_data", lut_lookup_cmp_data, cur_key);
        check("lpm_busy", lpm_busy, occ[0] == DEPTH);
        check("cccp_busy", cccp_busy, occ[1] == DEPTH);
        check("timeout_cnt", timeout_cnt, m_tmo);
        check("drop_cnt", drop_cnt, m_drop);

        if (lpm_ack)  n_lpm_ack++;
        if (cccp_ack) begin
            n_cccp_ack++;
            last_cccp_ack_cyc = cyc;
        end
        if (lut_lookup_req) begin
            last_req_cyc = cyc;
            obs_log.push_back(lut_lookup_cmp_data[31:24] == 8'h0B);
        end

        // Arbitration: a key is eligible the cycle after it was accepted.
        if (!outst) begin
            v0 = (mq_cyc[0].size() > 0) && (mq_cyc[0][0] < cyc);
            v1 = (mq_cyc[1].size() > 0) && (mq_cyc[1][0] < cyc);
            if (v0 || v1) begin
                owner     = (v0 && v1) ? m_rr : (v1 ? 1 : 0);
                outst     = 1'b1;
                issue_cyc = cyc + 1;
                cur_key   = mq_key[owner][0];
                lat       = pick_latency();
                cur_tmo   = (lat < 0);
                done_cyc  = cur_tmo ? issue_cyc + TMO + 1 : issue_cyc + lat;
            end
        end

        // CAM side: real ack, optional stale ack while no lookup is in flight, else noise.
        if (outst && !cur_tmo && done_cyc == cyc) begin
            rsp             = cam(cur_key);
            lut_lookup_ack  = 1'b1;
            lut_lookup_hit  = rsp[48];
            lut_lookup_data = rsp[47:0];
        end else if (stale_at == cyc && (!outst || issue_cyc > cyc)) begin
            lut_lookup_ack  = 1'b1;
            lut_lookup_hit  = 1'b1;
            lut_lookup_data = 48'hDEAD_BEEF_0BAD;
        end else begin
            lut_lookup_ack  = 1'b0;
            lut_lookup_hit  = 1'($urandom());
            lut_lookup_data = 48'({$urandom(), $urandom()});
        end

        lpm_req  = lreq;
        lpm_ip   = lip;
        cccp_req = creq;
        cccp_ip  = cip;
        reset    = rst;

        // Effect of the coming clock edge.
        acc0 = lreq && (occ[0] != DEPTH);
        acc1 = creq && (occ[1] != DEPTH);
        if (rst) begin
            for (int r = 0; r < 2; r++) begin
                mq_key[r].delete();
                mq_cyc[r].delete();
                occ[r] = 0;
            end
            outst = 1'b0; m_rr = 0; exp_ack_cyc = -1; m_tmo = 0; m_drop = 0;
        end else begin
            if (outst && done_cyc == cyc) begin
                void'(mq_key[owner].pop_front());
                void'(mq_cyc[owner].pop_front());
                occ[owner]--;
                exp_ack_cyc = cyc + 1;
                exp_port    = owner;
                if (cur_tmo) begin
                    exp_hit = 1'b0;
                    exp_mac = '0;
                    if (m_tmo < 16'hFFFF) m_tmo++;
                end else begin
                    rsp     = cam(cur_key);
                    exp_hit = rsp[48];
                    exp_mac = rsp[47:0];
                end
                m_rr  = 1 - owner;
                outst = 1'b0;
            end
            if (lreq && !acc0 && m_drop < 16'hFFFF) m_drop++;
            if (creq && !acc1 && m_drop < 16'hFFFF) m_drop++;
            if (acc0) begin mq_key[0].push_back(lip); mq_cyc[0].push_back(cyc); occ[0]++; end
            if (acc1) begin mq_key[1].push_back(cip); mq_cyc[1].push_back(cyc); occ[1]++; end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    // Called between negedge and the next posedge, right after a post-reset step.
    task automatic check_zero(input string tag);
        check({tag, "_lpm_busy"},  lpm_busy, 0);
        check({tag, "_cccp_busy"}, cccp_busy, 0);
        check({tag, "_lpm_ack"},   lpm_ack, 0);
        check({tag, "_cccp_ack"},  cccp_ack, 0);
        check({tag, "_lpm_hit"},   lpm_hit, 0);
        check({tag, "_cccp_hit"},  cccp_hit, 0);
        check({tag, "_lpm_mac"},   lpm_mac, 0);
        check({tag, "_cccp_mac"},  cccp_mac, 0);
        check({tag, "_lut_req"},   lut_lookup_req, 0);
        check({tag, "_cmp_data"},  lut_lookup_cmp_data, 0);
        check({tag, "_tmo_cnt"},   timeout_cnt, 0);
        check({tag, "_drop_cnt"},  drop_cnt, 0);
    endtask

    initial begin
        int base_l, base_c;
        bit exp_order[4];
        logic [31:0] lk, ck;
        bit lr, cr;
        occ[0] = 0;
        occ[1] = 0;
        repeat (3) @(posedge clk);

        // Reset values.
        do_reset();
        idle(1);
        check_zero("reset");
        idle(2);

        // Single LPM lookup, ack two cycles after the request.
        lat_mode = 2;
        base_l = n_lpm_ack; base_c = n_cccp_ack;
        step(1'b1, 32'h0A00_0001, 1'b0, '0, 1'b0);
        idle(10);
        check("single_lpm_acks", n_lpm_ack - base_l, 1);
        check("single_cccp_acks", n_cccp_ack - base_c, 0);

        // Contention: two keys queued on each side in the same cycles.
        do_reset();
        lat_mode = 1;
        obs_log.delete();
        step(1'b1, 32'h0A00_0101, 1'b1, 32'h0B00_0101, 1'b0);
        step(1'b1, 32'h0A00_0102, 1'b1, 32'h0B00_0102, 1'b0);
        idle(20);
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
        check("contention_grants", obs_log.size(), 4);
        for (int i = 0; i < 4 && i < obs_log.size(); i++)
            check($sformatf("contention_grant%0d", i), obs_log[i], exp_order[i]);

        // Overflow: three back-to-back LPM requests with the CAM stalled.
        do_reset();
        lat_mode = 12;
        base_l = n_lpm_ack;
        step(1'b1, 32'h0A00_0201, 1'b0, '0, 1'b0);
        step(1'b1, 32'h0A00_0202, 1'b0, '0, 1'b0);
        step(1'b1, 32'h0A00_0203, 1'b0, '0, 1'b0);
        idle(40);
        check("ovf_drop_cnt", drop_cnt, 1);
        check("ovf_lpm_acks", n_lpm_ack - base_l, 2);

        // Timeout, then a late ack five cycles after the miss result.
        lat_mode = -1;
        base_l = n_lpm_ack; base_c = n_cccp_ack;
        stale_at = cyc + 25;
        step(1'b0, '0, 1'b1, 32'h0B00_0301, 1'b0);
        idle(35);
        check("tmo_latency", last_cccp_ack_cyc - last_req_cyc, TMO + 2);
        check("tmo_cnt", timeout_cnt, 1);
        check("tmo_cccp_acks", n_cccp_ack - base_c, 1);
        check("tmo_lpm_acks", n_lpm_ack - base_l, 0);

        // Reset while WAITing, then an ack that must be ignored.
        step(1'b1, 32'h0A00_0401, 1'b0, '0, 1'b0);
        idle(6);
        do_reset();
        stale_at = cyc;
        idle(1);
        check_zero("midwait");
        base_l = n_lpm_ack;
        idle(4);
        check("midwait_no_ack", n_lpm_ack - base_l, 0);
        lat_mode = 1;
        step(1'b1, 32'h0A00_0402, 1'b0, '0, 1'b0);
        idle(8);
        check("midwait_next_ack", n_lpm_ack - base_l, 1);

        // Random traffic.
        lat_mode = -2;
        lk = 32'h0A10_0000;
        ck = 32'h0B10_0000;
        for (int i = 0; i < 2500; i++) begin
            lr = ($urandom_range(0, 99) < 30);
            cr = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 39) == 0) stale_at = cyc;
            step(lr, lk, cr, ck, 1'b0);
            if (lr) lk++;
            if (cr) ck++;
        end
        lat_mode = 1;
        idle(60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
